// File: rtl/stream_input_adapter.sv
// Ingress adapter: external valid/ready words -> small FWFT FIFO -> core input handshake.
// Tracks a per-operation word count, checks the last marker against it, reports done/err.
module stream_input_adapter #(
  parameter int w     = 64,
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] in_words,
  input  logic             valid_i,
  output logic             ready_i,
  input  logic [w-1:0]     data_i,
  input  logic             last_i,
  output logic             dilithium_valid_i,
  input  logic             dilithium_ready_i,
  output logic [w-1:0]     dilithium_data_i,
  output logic             done,
  output logic             err
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [w-1:0]     r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [LEN_W-1:0] r_remaining;
  logic             r_err;
  logic             r_done_zero;

  logic w_empty;
  logic w_full;
  logic w_ready;
  logic w_valid;
  logic w_accept;
  logic w_deliver;
  logic w_flush;
  logic w_set_err;
  logic w_drain_done;
  logic w_rem_one;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_rem_one = (r_remaining == LEN_W'(1));

  // start always wins: it blocks both handshakes in its own cycle so nothing
  // from the aborted operation is accepted or delivered.
  assign w_ready   = (r_state == S_STREAM) && !w_full && !start;
  assign w_valid   = !w_empty && ((r_state == S_STREAM) || (r_state == S_DRAIN)) && !start;
  assign w_accept  = valid_i && w_ready;
  assign w_deliver = w_valid && dilithium_ready_i;

  always_comb begin
    w_state_nxt  = r_state;
    w_flush      = 1'b0;
    w_set_err    = 1'b0;
    w_drain_done = 1'b0;
    if (start) begin
      w_flush     = 1'b1;
      w_state_nxt = (in_words != '0) ? S_STREAM : S_IDLE;
    end else begin
      unique case (r_state)
        S_STREAM: begin
          if (w_accept) begin
            if (w_rem_one && last_i) begin
              w_state_nxt = S_DRAIN;
            end else if (w_rem_one || last_i) begin
              w_state_nxt = S_ERR;
              w_set_err   = 1'b1;
              w_flush     = 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            w_drain_done = 1'b1;
            w_state_nxt  = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_err       <= 1'b0;
      r_done_zero <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_done_zero <= start && (in_words == '0);
      if (start) begin
        r_remaining <= in_words;
      end else if (w_accept) begin
        r_remaining <= r_remaining - LEN_W'(1);
      end
      if (start) begin
        r_err <= 1'b0;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end
    end
  end

  // Flush overrides any write/read in the same cycle, which also drops the
  // word whose last marker caused a framing error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_deliver) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      end
      unique case ({w_accept, w_deliver})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !w_flush) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  assign ready_i           = w_ready;
  assign dilithium_valid_i = w_valid;
  assign dilithium_data_i  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign done              = r_done_zero | w_drain_done;
  assign err               = r_err;

endmodule

// File: tb/tb_stream_input_adapter.sv
// Scoreboard bench for stream_input_adapter: words pushed on external accept,
// popped and compared on core delivery; per-scenario tasks check done/err/ready.
module tb_stream_input_adapter;

  localparam int W  = 64;
  localparam int D  = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] in_words = '0;
  logic          valid_i = 1'b0;
  logic          ready_i;
  logic [W-1:0]  data_i = '0;
  logic          last_i = 1'b0;
  logic          dv;
  logic          dr = 1'b0;
  logic [W-1:0]  dd;
  logic          done;
  logic          err;

  stream_input_adapter #(.w(W), .DEPTH(D), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_words(in_words),
    .valid_i(valid_i), .ready_i(ready_i), .data_i(data_i), .last_i(last_i),
    .dilithium_valid_i(dv), .dilithium_ready_i(dr), .dilithium_data_i(dd),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [W-1:0] sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_acc, n_del, n_done, first_del_cyc, last_del_cyc, done_cyc, err_cyc, last_acc_cyc, drop_acc;
  int start_cyc;
  bit acc_now;

  task automatic clear_stats();
    n_acc = 0; n_del = 0; n_done = 0;
    first_del_cyc = -1; last_del_cyc = -1; done_cyc = -1;
    err_cyc = -1; last_acc_cyc = -1; drop_acc = -1;
  endtask

  // Inputs are driven at the negedge; everything is sampled 1 time unit later.
  task automatic tick();
    logic [W-1:0] exp_w;
    #1;
    acc_now = valid_i && ready_i;
    if (valid_i && !ready_i && drop_acc < 0) drop_acc = n_acc;
    if (acc_now) begin
      sb.push_back(data_i);
      n_acc++;
      last_acc_cyc = cyc;
    end
    if (dv && dr) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL deliver_extra got=%h required=none", dd);
      end else begin
        exp_w = sb.pop_front();
        if (dd !== exp_w) begin
          bad++;
          $display("FAIL deliver_data got=%h required=%h", dd, exp_w);
        end
      end
      if (first_del_cyc < 0) first_del_cyc = cyc;
      last_del_cyc = cyc;
      n_del++;
    end
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (err === 1'b1 && err_cyc < 0) err_cyc = cyc;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    last_i  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_start(input logic [LW-1:0] n);
    start    = 1'b1;
    in_words = n;
    valid_i  = 1'b0;
    start_cyc = cyc;
    tick();
    start    = 1'b0;
  endtask

  task automatic send(input int n, input int last_at, input logic [W-1:0] base,
                      input int ready_on, input int budget);
    int k = 1;
    int spent = 0;
    while (k <= n && spent < budget) begin
      valid_i = 1'b1;
      data_i  = base + W'(k);
      last_i  = (k == last_at);
      dr      = (cyc >= ready_on);
      tick();
      spent++;
      if (acc_now) k++;
      if (err_cyc >= 0) break;
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    if (k <= n && err_cyc < 0) begin
      total++; bad++;
      $display("FAIL send_timeout accepted=%0d required=%0d", k - 1, n);
    end
  endtask

  task automatic wait_done(input int budget);
    int spent = 0;
    dr = 1'b1;
    while (n_done == 0 && spent < budget) begin
      tick();
      spent++;
    end
    if (n_done == 0) begin
      total++; bad++;
      $display("FAIL done_timeout done_count=%0d required=1", n_done);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (ready_i !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b required=0", ready_i); end
    total++; if (dv !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b required=0", dv); end
    total++; if (dd !== '0) begin bad++; $display("FAIL reset_data got=%h required=0", dd); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b required=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b required=0", err); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic(input logic [W-1:0] base);
    clear_stats();
    dr = 1'b1;
    do_start(16'd5);
    send(5, 5, base, 0, 20);
    wait_done(20);
    idle(3);
    total++; if (n_del !== 5) begin bad++; $display("FAIL basic_count got=%0d required=5", n_del); end
    total++; if (first_del_cyc !== start_cyc + 2) begin bad++; $display("FAIL basic_latency got=%0d required=%0d", first_del_cyc, start_cyc + 2); end
    total++; if (last_del_cyc - first_del_cyc !== 4) begin bad++; $display("FAIL basic_consecutive got=%0d required=4", last_del_cyc - first_del_cyc); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL basic_done_count got=%0d required=1", n_done); end
    total++; if (done_cyc !== last_del_cyc + 1) begin bad++; $display("FAIL basic_done_cycle got=%0d required=%0d", done_cyc, last_del_cyc + 1); end
    total++; if (err !== 1'b0 || err_cyc !== -1) begin bad++; $display("FAIL basic_err got=%b required=0", err); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL basic_leftover got=%0d required=0", sb.size()); end
  endtask

  task automatic test_backpressure();
    clear_stats();
    dr = 1'b0;
    do_start(16'd8);
    send(8, 8, 64'hB000, start_cyc + 10, 40);
    wait_done(40);
    idle(3);
    total++; if (drop_acc !== D) begin bad++; $display("FAIL bp_ready_drop got=%0d required=%0d", drop_acc, D); end
    total++; if (n_del !== 8) begin bad++; $display("FAIL bp_count got=%0d required=8", n_del); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL bp_done_count got=%0d required=1", n_done); end
    total++; if (done_cyc !== last_del_cyc + 1) begin bad++; $display("FAIL bp_done_cycle got=%0d required=%0d", done_cyc, last_del_cyc + 1); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL bp_err got=%b required=0", err); end
  endtask

  task automatic test_early_last();
    clear_stats();
    dr = 1'b1;
    do_start(16'd6);
    send(6, 3, 64'hE000, 0, 20);
    total++; if (err_cyc !== last_acc_cyc + 1) begin bad++; $display("FAIL early_err_cycle got=%0d required=%0d", err_cyc, last_acc_cyc + 1); end
    total++; if (ready_i !== 1'b0) begin bad++; $display("FAIL early_ready got=%b required=0", ready_i); end
    total++; if (dv !== 1'b0) begin bad++; $display("FAIL early_valid got=%b required=0", dv); end
    idle(5);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL early_err_sticky got=%b required=1", err); end
    total++; if (n_done !== 0) begin bad++; $display("FAIL early_no_done got=%0d required=0", n_done); end
    total++; if (n_del !== 2) begin bad++; $display("FAIL early_delivered got=%0d required=2", n_del); end
    sb.delete();
    clear_stats();
    do_start(16'd1);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL early_err_clear got=%b required=0", err); end
    send(1, 1, 64'hE100, 0, 10);
    wait_done(10);
    total++; if (n_done !== 1 || n_del !== 1) begin bad++; $display("FAIL early_recover got=done%0d/del%0d required=1/1", n_done, n_del); end
    idle(2);
  endtask

  task automatic test_missing_last();
    clear_stats();
    dr = 1'b0;
    do_start(16'd2);
    send(2, 0, 64'hA000, 1 << 30, 10);
    dr = 1'b1;
    idle(6);
    total++; if (err_cyc !== last_acc_cyc + 1) begin bad++; $display("FAIL missing_err_cycle got=%0d required=%0d", err_cyc, last_acc_cyc + 1); end
    total++; if (n_del !== 0) begin bad++; $display("FAIL missing_forwarded got=%0d required=0", n_del); end
    total++; if (n_done !== 0) begin bad++; $display("FAIL missing_no_done got=%0d required=0", n_done); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL missing_err got=%b required=1", err); end
    sb.delete();
  endtask

  task automatic test_abort();
    clear_stats();
    dr = 1'b0;
    do_start(16'd5);
    send(2, 0, 64'hC000, 1 << 30, 10);
    sb.delete();
    dr       = 1'b1;
    start    = 1'b1;
    in_words = 16'd3;
    #1;
    total++; if (ready_i !== 1'b0) begin bad++; $display("FAIL abort_start_ready got=%b required=0", ready_i); end
    total++; if (dv !== 1'b0) begin bad++; $display("FAIL abort_start_valid got=%b required=0", dv); end
    clear_stats();
    tick();
    start = 1'b0;
    total++; if (dv !== 1'b0) begin bad++; $display("FAIL abort_flushed got=%b required=0", dv); end
    send(3, 3, 64'hC100, 0, 20);
    wait_done(20);
    idle(3);
    total++; if (n_del !== 3) begin bad++; $display("FAIL abort_count got=%0d required=3", n_del); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL abort_done_count got=%0d required=1", n_done); end
  endtask

  task automatic test_zero_len();
    clear_stats();
    dr = 1'b1;
    do_start(16'd0);
    idle(4);
    total++; if (n_done !== 1) begin bad++; $display("FAIL zero_done_count got=%0d required=1", n_done); end
    total++; if (done_cyc !== start_cyc + 1) begin bad++; $display("FAIL zero_done_cycle got=%0d required=%0d", done_cyc, start_cyc + 1); end
    total++; if (n_del !== 0) begin bad++; $display("FAIL zero_data got=%0d required=0", n_del); end
  endtask

  task automatic test_async_reset();
    clear_stats();
    dr = 1'b0;
    do_start(16'd4);
    send(4, 4, 64'hD000, 1 << 30, 20);
    total++; if (dv !== 1'b1) begin bad++; $display("FAIL areset_pre_valid got=%b required=1", dv); end
    #3;
    rst = 1'b1;
    #1;
    total++; if (ready_i !== 1'b0) begin bad++; $display("FAIL areset_ready got=%b required=0", ready_i); end
    total++; if (dv !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b required=0", dv); end
    total++; if (dd !== '0) begin bad++; $display("FAIL areset_data got=%h required=0", dd); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL areset_done got=%b required=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL areset_err got=%b required=0", err); end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    test_basic(64'hF000);
  endtask

  initial begin
    test_reset();
    test_basic(64'h1000);
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_abort();
    test_zero_len();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required=finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/stream_input_adapter.md
Name: stream_input_adapter

Overview:
- Ingress counterpart of the egress adapter. Accepts words from the external valid/ready port and feeds the Dilithium core input handshake through a small FIFO.
- Enforces a per-operation word count latched at start, checks the external last marker against it, and reports completion or a framing error.
- Sits between the external input IO and the Dilithium core data input.

Parameters:
- w, 64, data word width in bits.
- DEPTH, 4, FIFO depth in words; legal range 2..16.
- LEN_W, 16, width of the word-count port and internal counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  one-cycle pulse; latches in_words and begins an operation.
- in_words  input  LEN_W  number of words expected for this operation; sampled only on start.
- valid_i  input  1  external word valid.
- ready_i  output  1  adapter accepts the external word this cycle.
- data_i  input  w  external word.
- last_i  input  1  external marker for the final word; qualified by valid_i && ready_i.
- dilithium_valid_i  output  1  word available to the core.
- dilithium_ready_i  input  1  core accepts the word.
- dilithium_data_i  output  w  word to the core.
- done  output  1  one-cycle pulse: all in_words words delivered to the core.
- err  output  1  sticky framing error; cleared by start or rst.

Behaviour:
- Reset: state IDLE, FIFO empty, counter 0. Outputs ready_i=0, dilithium_valid_i=0, dilithium_data_i=0, done=0, err=0.
- Accept = valid_i && ready_i. Deliver = dilithium_valid_i && dilithium_ready_i.
- FIFO behaviour:
  - Register-based, first-word-fall-through.
  - dilithium_valid_i = !empty; dilithium_data_i = head word. Head word is 0 when empty.
  - A word accepted at edge N is visible on dilithium_data_i after edge N; latency is 1 cycle.
  - Write and read in the same cycle are both honoured; occupancy is unchanged.
  - Write while full is impossible because ready_i is gated.
  - Throughput is 1 word/cycle when dilithium_ready_i is held high.
- State IDLE:
  - ready_i=0.
  - On start with in_words>0: latch remaining=in_words, clear err, go to STREAM.
  - On start with in_words==0: done=1 on the next cycle, stay IDLE.
- State STREAM:
  - ready_i = !full, combinational from the registered FIFO count. No dependence on valid_i.
  - Each accept decrements remaining.
  - Accept with remaining==1 and last_i=1: go to DRAIN.
  - Accept with remaining==1 and last_i=0: set err, go to ERR (missing last).
  - Accept with remaining>1 and last_i=1: set err, go to ERR (early last).
- State DRAIN:
  - ready_i=0; the FIFO keeps delivering.
  - The cycle after the FIFO becomes empty: done=1 for one cycle, go to IDLE.
  - If the final word is accepted and delivered in the same cycle with the FIFO otherwise empty, done still fires exactly once, one cycle later.
- State ERR:
  - ready_i=0, dilithium_valid_i=0, FIFO flushed; the word that triggered the error is not written.
  - err=1 is held until start or rst. No done pulse.
- start outside IDLE: abort the current operation.
  - Flush the FIFO, clear err, reload remaining.
  - Next state follows the IDLE rules above.
  - The start cycle has ready_i=0 and dilithium_valid_i=0. No done for the aborted operation.
- rst asserted mid-operation: all state returns to reset values immediately. In-flight words are discarded.
- Counter width: remaining is LEN_W bits and never wraps, because acceptance stops at 0.

Test Plan:
- Basic transfer: in_words=5, valid_i held high, dilithium_ready_i=1, last_i on the 5th word.
  - Required: 5 words delivered in order on consecutive cycles; done pulses once, 1 cycle after the last delivery; err=0.
- Backpressure: in_words=8, DEPTH=4, dilithium_ready_i=0 for 10 cycles, then 1.
  - Required: ready_i falls after 4 accepts; all 8 words delivered intact and ordered; done pulses once.
- Early last: in_words=6, last_i on word 3.
  - Required: err=1 from the next cycle; dilithium_valid_i=0; ready_i=0; no done; next start clears err.
- Missing last: in_words=2, last_i never asserted.
  - Required: err=1 after the 2nd accept; words not forwarded past the flush; no done.
- Abort and zero length: start mid-STREAM with in_words=3 after 2 words buffered; separately, start with in_words=0.
  - Required (abort): FIFO empties, only the 3 new words are delivered, single done.
  - Required (zero length): done 1 cycle after start, no data.
- Async reset mid-DRAIN: assert rst asynchronously.
  - Required: all outputs 0 without waiting for a clk edge; the next operation behaves as the basic transfer case.
